line_window_gen: RTL and testbench

//  Parametrised KxK sliding-window generator for the edge-detection pipeline.

---
 rtl/win_pkg.sv | 18 +
 rtl/line_window_gen_if.sv | 48 ++++
 rtl/line_ram.sv | 40 ++++
 rtl/line_window_gen.sv | 215 +++++++++++++++++++++
 tb/tb_line_window_gen.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared constants and window-layout helper for line_window_gen
// Contents:
//   CNT_W        width of the column/row position counters
//   BORDER_REPL  border mode: replicate nearest valid pixel
//   BORDER_ZERO  border mode: zero fill
//   win_idx()    bit offset of window element (i,j) in the flattened window bus
package win_pkg;

  localparam int CNT_W       = 12;
  localparam int BORDER_REPL = 0;
  localparam int BORDER_ZERO = 1;

  // Row-major flattening: element (0,0) sits in the LSBs, (K-1,K-1) in the MSBs.
  function automatic int win_idx(input int i, input int j, input int k, input int dw);
    return (i * k + j) * dw;
  endfunction

endpackage

// File: rtl/line_window_gen_if.sv
// rtl/line_window_gen_if.sv - pixel-in / window-out signal bundle for line_window_gen
// Signals:
//   din_vld   pixel valid
//   din_sof   start of frame, qualified by din_vld
//   din       pixel, DW bits
//   dout_vld  window valid
//   win_data  flattened KxK window, K*K*DW bits
//   win_col   column of the window's bottom-right element (WIN_POS_EN only)
//   win_row   row of the window's bottom-right element    (WIN_POS_EN only)
// Modports: master = pixel source / window sink, slave = window generator.
// Optional feature macro: WIN_POS_EN.
interface line_window_gen_if #(
  parameter int DW = 8,
  parameter int K  = 3
);

  logic              din_vld;
  logic              din_sof;
  logic [DW-1:0]     din;
  logic              dout_vld;
  logic [K*K*DW-1:0] win_data;

`ifdef WIN_POS_EN
  logic [win_pkg::CNT_W-1:0] win_col;
  logic [win_pkg::CNT_W-1:0] win_row;

  modport master (
    output din_vld, din_sof, din,
    input  dout_vld, win_data, win_col, win_row
  );

  modport slave (
    input  din_vld, din_sof, din,
    output dout_vld, win_data, win_col, win_row
  );
`else
  modport master (
    output din_vld, din_sof, din,
    input  dout_vld, win_data
  );

  modport slave (
    input  din_vld, din_sof, din,
    output dout_vld, win_data
  );
`endif

endinterface

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port line buffer RAM, one-cycle synchronous read, read-first
// Ports:
//   clk        clock
//   wr_en_i    write enable
//   wr_addr_i  write address
//   wr_data_i  write data, WIDTH bits
//   rd_en_i    read enable; rd_data_o updates on the following edge
//   rd_addr_i  read address
//   rd_data_o  registered read data (holds when rd_en_i is low)
module line_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 640,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Both ports update with non-blocking assignments, so a same-address
  // read returns the old contents (read-first). Contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_window_gen.sv
// rtl/line_window_gen.sv - KxK sliding-window generator over a raster pixel stream
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    line_window_gen_if.slave: din_vld/din_sof/din in, dout_vld/win_data out
//          (plus win_col/win_row when WIN_POS_EN is defined)
// Parameters: DW pixel bits, K window size (3 or 5), H_DISP pixels per line,
//   V_DISP lines per frame, BORDER (0 replicate, 1 zero fill).
// Optional feature macro: WIN_POS_EN (window position outputs).
// Pipeline: stage 0 reads the line RAM and registers the pixel and its position;
// stage 1 writes the shifted line taps back, builds the new column and shifts it
// into the window registers. Output appears two cycles after the input pixel.
module line_window_gen
  import win_pkg::*;
#(
  parameter int DW     = 8,
  parameter int K      = 3,
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  parameter int BORDER = BORDER_REPL
) (
  input  logic clk,
  input  logic rst_n,
  line_window_gen_if.slave bus
);

  localparam int AW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int TW = (K - 1) * DW;

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] cnt_col_q, cnt_col_d;
  logic [CNT_W-1:0] cnt_row_q, cnt_row_d;
  logic [CNT_W-1:0] pix_col, pix_row;

  // Position of the pixel currently on din; sof forces it to (0,0) and the
  // counters continue from there, which also recovers from a truncated frame.
  always_comb begin
    pix_col   = bus.din_sof ? '0 : cnt_col_q;
    pix_row   = bus.din_sof ? '0 : cnt_row_q;
    cnt_col_d = cnt_col_q;
    cnt_row_d = cnt_row_q;
    if (bus.din_vld) begin
      if (pix_col == CNT_W'(H_DISP - 1)) begin
        cnt_col_d = '0;
        cnt_row_d = (pix_row == CNT_W'(V_DISP - 1)) ? '0 : pix_row + CNT_W'(1);
      end else begin
        cnt_col_d = pix_col + CNT_W'(1);
        cnt_row_d = pix_row;
      end
    end
  end

  // ----------------------------------------------------------------- stage 0
  logic             s1_vld_q;
  logic [DW-1:0]    s1_din_q;
  logic [CNT_W-1:0] s1_col_q;
  logic [CNT_W-1:0] s1_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_col_q <= '0;
      cnt_row_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_din_q  <= '0;
      s1_col_q  <= '0;
      s1_row_q  <= '0;
    end else begin
      cnt_col_q <= cnt_col_d;
      cnt_row_q <= cnt_row_d;
      s1_vld_q  <= bus.din_vld;
      if (bus.din_vld) begin
        s1_din_q <= bus.din;
        s1_col_q <= pix_col;
        s1_row_q <= pix_row;
      end
    end
  end

  // --------------------------------------------------------------- line RAM
  // Slot t-1 of a RAM word holds the pixel t rows above the current one.
  logic [TW-1:0] tap_rd;
  logic [TW-1:0] tap_wr;

  // Push the current pixel into slot 0 and age every older row by one slot;
  // the oldest row falls off the top.
  assign tap_wr = {tap_rd[TW-DW-1:0], s1_din_q};

  line_ram #(
    .WIDTH (TW),
    .DEPTH (H_DISP),
    .AW    (AW)
  ) u_line_ram (
    .clk       (clk),
    .wr_en_i   (s1_vld_q),
    .wr_addr_i (s1_col_q[AW-1:0]),
    .wr_data_i (tap_wr),
    .rd_en_i   (bus.din_vld),
    .rd_addr_i (pix_col[AW-1:0]),
    .rd_data_o (tap_rd)
  );

  // ----------------------------------------------------------------- stage 1
  // col_src[t]: pixel t rows above the current pixel in this column.
  logic [DW-1:0] col_src [K];
  logic [DW-1:0] new_col [K];
  logic [DW-1:0] clamp_px;

  always_comb begin
    col_src[0] = s1_din_q;
    for (int t = 1; t < K; t++) begin
      col_src[t] = tap_rd[(t-1)*DW +: DW];
    end
  end

  // Taps above row 0 of the frame hold stale data; replace them with the
  // row-0 pixel of this column (replicate) or with zero.
  always_comb begin
    clamp_px = col_src[0];
    for (int t = 1; t < K; t++) begin
      if (s1_row_q == CNT_W'(t)) begin
        clamp_px = col_src[t];
      end
    end
    new_col[0] = s1_din_q;
    for (int t = 1; t < K; t++) begin
      if (s1_row_q >= CNT_W'(t)) begin
        new_col[t] = col_src[t];
      end else if (BORDER == BORDER_REPL) begin
        new_col[t] = clamp_px;
      end else begin
        new_col[t] = '0;
      end
    end
  end

  // ------------------------------------------------------------ window regs
  // win_q[i][j]: i = row (0 oldest), j = column (0 oldest).
  logic [DW-1:0] win_q [K][K];
  logic [DW-1:0] win_d [K][K];
  logic          dout_vld_q;
  logic          first_col;

  assign first_col = (s1_col_q == '0);

  // Window row i takes new_col[K-1-i]. At column 0 the columns to the left
  // lie outside the image, so they are refilled instead of shifted.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        if (!first_col) begin
          win_d[i][j] = win_q[i][j+1];
        end else if (BORDER == BORDER_REPL) begin
          win_d[i][j] = new_col[K-1-i];
        end else begin
          win_d[i][j] = '0;
        end
      end
      win_d[i][K-1] = new_col[K-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_vld_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      dout_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            win_q[i][j] <= win_d[i][j];
          end
        end
      end
    end
  end

  logic [K*K*DW-1:0] win_flat;

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_flat[win_idx(i, j, K, DW) +: DW] = win_q[i][j];
      end
    end
  end

  assign bus.dout_vld = dout_vld_q;
  assign bus.win_data = win_flat;

`ifdef WIN_POS_EN
  // Position of the window's bottom-right element, aligned with dout_vld.
  logic [CNT_W-1:0] win_col_q;
  logic [CNT_W-1:0] win_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_col_q <= '0;
      win_row_q <= '0;
    end else if (s1_vld_q) begin
      win_col_q <= s1_col_q;
      win_row_q <= s1_row_q;
    end
  end

  assign bus.win_col = win_col_q;
  assign bus.win_row = win_row_q;
`endif

endmodule

// File: tb/tb_line_window_gen.sv
// tb/tb_line_window_gen.sv - self-checking bench for line_window_gen (K=3 both borders, K=5)
module tb_line_window_gen;

  localparam int DWA = 8;
  localparam int KA  = 3;
  localparam int HA  = 4;
  localparam int VA  = 4;
  localparam int DWC = 10;
  localparam int KC  = 5;
  localparam int HC  = 8;
  localparam int VC  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_window_gen_if #(.DW(DWA), .K(KA)) if_a ();
  line_window_gen_if #(.DW(DWA), .K(KA)) if_b ();
  line_window_gen_if #(.DW(DWC), .K(KC)) if_c ();

  line_window_gen #(.DW(DWA), .K(KA), .H_DISP(HA), .V_DISP(VA), .BORDER(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  line_window_gen #(.DW(DWA), .K(KA), .H_DISP(HA), .V_DISP(VA), .BORDER(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  line_window_gen #(.DW(DWC), .K(KC), .H_DISP(HC), .V_DISP(VC), .BORDER(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference images indexed by frame position, and the bench's own position counters.
  int img_a [VA][HA];
  int img_c [VC][HC];
  int pos_ra = 0, pos_ca = 0, pos_rc = 0, pos_cc = 0;

  logic [255:0] qa [$];
  logic [255:0] qb [$];
  logic [255:0] qc [$];
  int           pa [$];
  int           pc [$];
  logic [255:0] last_a = '0, last_b = '0, last_c = '0;
  logic [255:0] ea, eb, ec;
  logic [1:0]   vh_ab = '0, vh_c = '0;

  // Window element (i,j) is image pixel (r-K+1+i, c-K+1+j); off-image
  // coordinates clamp to 0 (replicate) or read as zero.
  function automatic logic [255:0] model_win(input bit sel_c, input int border,
                                             input int r, input int c);
    logic [255:0] w;
    int k, dw, rr, cc, v;
    w  = '0;
    k  = sel_c ? KC : KA;
    dw = sel_c ? DWC : DWA;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        rr = r - (k - 1) + i;
        cc = c - (k - 1) + j;
        if (border == 0) begin
          if (rr < 0) rr = 0;
          if (cc < 0) cc = 0;
        end
        if (rr < 0 || cc < 0) v = 0;
        else v = sel_c ? img_c[rr][cc] : img_a[rr][cc];
        w = w | (256'(v) << ((i * k + j) * dw));
      end
    end
    return w;
  endfunction

  task automatic step_ab(input bit vld, input bit sof, input int base);
    int d;
    @(posedge clk); #1;
    if_a.din_vld = vld;
    if_b.din_vld = vld;
    if_a.din_sof = vld & sof;
    if_b.din_sof = vld & sof;
    if (vld) begin
      if (sof) begin
        pos_ra = 0;
        pos_ca = 0;
      end
      d = base + pos_ra * 16 + pos_ca;
      if_a.din = 8'(d);
      if_b.din = 8'(d);
      img_a[pos_ra][pos_ca] = d;
      qa.push_back(model_win(1'b0, 0, pos_ra, pos_ca));
      qb.push_back(model_win(1'b0, 1, pos_ra, pos_ca));
      pa.push_back(pos_ra * 4096 + pos_ca);
      pos_ca++;
      if (pos_ca == HA) begin
        pos_ca = 0;
        pos_ra = (pos_ra == VA - 1) ? 0 : pos_ra + 1;
      end
    end else begin
      if_a.din = 8'($urandom);
      if_b.din = if_a.din;
    end
  endtask

  task automatic step_c(input bit vld, input bit sof);
    int d;
    @(posedge clk); #1;
    if_c.din_vld = vld;
    if_c.din_sof = vld & sof;
    if (vld) begin
      if (sof) begin
        pos_rc = 0;
        pos_cc = 0;
      end
      d = pos_rc * HC + pos_cc;
      if_c.din = 10'(d);
      img_c[pos_rc][pos_cc] = d;
      qc.push_back(model_win(1'b1, 0, pos_rc, pos_cc));
      pc.push_back(pos_rc * 4096 + pos_cc);
      pos_cc++;
      if (pos_cc == HC) begin
        pos_cc = 0;
        pos_rc = (pos_rc == VC - 1) ? 0 : pos_rc + 1;
      end
    end else begin
      if_c.din = 10'($urandom);
    end
  endtask

  task automatic flush_ab();
    step_ab(1'b0, 1'b0, 0);
    step_ab(1'b0, 1'b0, 0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vh_ab <= '0;
      vh_c  <= '0;
    end else begin
      vh_ab <= {vh_ab[0], if_a.din_vld};
      vh_c  <= {vh_c[0], if_c.din_vld};
    end
  end

  // Output scoreboard: valid pattern, window contents, and hold during gaps.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete(); qb.delete(); qc.delete(); pa.delete(); pc.delete();
      last_a <= '0;
      last_b <= '0;
      last_c <= '0;
    end else begin
      check("a_vld", 256'(if_a.dout_vld), 256'(vh_ab[1]));
      check("b_vld", 256'(if_b.dout_vld), 256'(vh_ab[1]));
      check("c_vld", 256'(if_c.dout_vld), 256'(vh_c[1]));
      if (if_a.dout_vld) begin
        ea = (qa.size() > 0) ? qa.pop_front() : '1;
        check("a_win", 256'(if_a.win_data), ea);
        last_a <= ea;
`ifdef WIN_POS_EN
        if (pa.size() > 0) begin
          check("a_pos", 256'({if_a.win_row, if_a.win_col}), 256'(pa.pop_front()));
        end
`endif
      end else begin
        check("a_hold", 256'(if_a.win_data), last_a);
      end
      if (if_b.dout_vld) begin
        eb = (qb.size() > 0) ? qb.pop_front() : '1;
        check("b_win", 256'(if_b.win_data), eb);
        last_b <= eb;
      end else begin
        check("b_hold", 256'(if_b.win_data), last_b);
      end
      if (if_c.dout_vld) begin
        ec = (qc.size() > 0) ? qc.pop_front() : '1;
        check("c_win", 256'(if_c.win_data), ec);
        last_c <= ec;
`ifdef WIN_POS_EN
        if (pc.size() > 0) begin
          check("c_pos", 256'({if_c.win_row, if_c.win_col}), 256'(pc.pop_front()));
        end
`endif
      end else begin
        check("c_hold", 256'(if_c.win_data), last_c);
      end
    end
  end

  initial begin
    if_a.din_vld = 1'b0; if_a.din_sof = 1'b0; if_a.din = '0;
    if_b.din_vld = 1'b0; if_b.din_sof = 1'b0; if_b.din = '0;
    if_c.din_vld = 1'b0; if_c.din_sof = 1'b0; if_c.din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld_a", 256'(if_a.dout_vld), 256'(0));
    check("rst_win_a", 256'(if_a.win_data), 256'(0));
    check("rst_vld_b", 256'(if_b.dout_vld), 256'(0));
    check("rst_win_b", 256'(if_b.win_data), 256'(0));
    check("rst_vld_c", 256'(if_c.dout_vld), 256'(0));
    check("rst_win_c", 256'(if_c.win_data), 256'(0));
    rst_n = 1'b1;

    // Frame 1, gap-free apart from inspection pauses: din = row*16+col.
    step_ab(1'b1, 1'b1, 0);
    flush_ab();
    check("a_at_0_0", 256'(if_a.win_data), 256'(0));
    for (int n = 0; n < 4; n++) step_ab(1'b1, 1'b0, 0);
    flush_ab();
    check("a_at_1_0", 256'(if_a.win_data), 256'(72'h10_10_10_00_00_00_00_00_00));
    check("b_at_1_0", 256'(if_b.win_data), 256'(72'h10_00_00_00_00_00_00_00_00));
    for (int n = 0; n < 7; n++) step_ab(1'b1, 1'b0, 0);
    flush_ab();
    check("a_at_2_3", 256'(if_a.win_data), 256'(72'h23_22_21_13_12_11_03_02_01));
    check("b_at_2_3", 256'(if_b.win_data), 256'(72'h23_22_21_13_12_11_03_02_01));
    for (int n = 0; n < 4; n++) step_ab(1'b1, 1'b0, 0);
    flush_ab();

    // Frame 2 by wrap (no sof), din_vld toggling 1010...
    for (int n = 0; n < 16; n++) begin
      step_ab(1'b1, 1'b0, 0);
      step_ab(1'b0, 1'b0, 0);
    end
    flush_ab();

    // Frame 3: sof pulsed where (2,1) would be.
    for (int n = 0; n < 9; n++) step_ab(1'b1, 1'b0, 8'h80);
    step_ab(1'b1, 1'b1, 8'h80);
    flush_ab();
    check("a_sof_win", 256'(if_a.win_data), 256'(72'h80_80_80_80_80_80_80_80_80));
    check("b_sof_win", 256'(if_b.win_data), 256'(72'h80_00_00_00_00_00_00_00_00));
    for (int n = 0; n < 15; n++) step_ab(1'b1, 1'b0, 8'h80);
    flush_ab();

    // Frame 4: reset pulse where (2,2) would be.
    step_ab(1'b1, 1'b1, 0);
    for (int n = 0; n < 9; n++) step_ab(1'b1, 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    if_a.din_vld = 1'b0;
    if_b.din_vld = 1'b0;
    pos_ra = 0;
    pos_ca = 0;
    #2;
    check("mid_rst_vld_a", 256'(if_a.dout_vld), 256'(0));
    check("mid_rst_win_a", 256'(if_a.win_data), 256'(0));
    check("mid_rst_vld_b", 256'(if_b.dout_vld), 256'(0));
    check("mid_rst_win_b", 256'(if_b.win_data), 256'(0));
`ifdef WIN_POS_EN
    check("mid_rst_pos_a", 256'({if_a.win_row, if_a.win_col}), 256'(0));
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step_ab(1'b1, 1'b0, 8'h40);
    flush_ab();
    check("a_after_rst", 256'(if_a.win_data), 256'(72'h40_40_40_40_40_40_40_40_40));
    check("b_after_rst", 256'(if_b.win_data), 256'(72'h40_00_00_00_00_00_00_00_00));

    // K=5, DW=10, 8x6 ramp frame.
    step_c(1'b1, 1'b1);
    for (int n = 1; n < HC * VC; n++) step_c(1'b1, 1'b0);
    step_c(1'b0, 1'b0);
    step_c(1'b0, 1'b0);
    check("c_e00_at_5_7", 256'(if_c.win_data[9:0]), 256'(11));
    check("c_e44_at_5_7", 256'(if_c.win_data[249:240]), 256'(8'h2F));

    repeat (4) @(posedge clk);
    #1;
    check("a_drained", 256'(qa.size()), 256'(0));
    check("c_drained", 256'(qc.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
